// File: rtl/sift_kp_collect.sv
// ---------------------------------------------------------------------------
// sift_kp_collect
//
// Purpose:
//   Sits after sift_feat and turns its per-pixel output stream into a queue
//   of keypoint records. The block tracks the raster position of every
//   output pixel and packs each keypoint as {y, x, mag, dir}. Records go
//   into a first-word-fall-through FIFO whose read side is a valid/ready
//   port. Per-frame keypoint and drop counts are kept. Frame completion is
//   flagged once the FIFO has drained.
//
// Build option:
//   SIFT_KP_NMS_EN - when defined, enables horizontal adjacency suppression.
//                    A run of horizontally adjacent keypoints in one row
//                    collapses to its first pixel. Suppressed pixels count
//                    neither as accepted nor as dropped.
//
// Ports:
//   clk_sys     in   system clock, rising edge
//   rst_sys     in   asynchronous reset, active low
//   start       in   one-cycle pulse: flush everything and begin a frame
//   pix_en      in   one output pixel present this cycle
//   kp_in       in   current pixel is a keypoint
//   mag[7:0]    in   gradient magnitude of the current pixel
//   dir[5:0]    in   gradient direction bin of the current pixel
//   frame_done  in   upstream completion pulse
//   m_valid     out  m_data holds a valid record
//   m_ready     in   consumer accepts the record
//   m_data      out  {y, x, mag, dir}, MSB first (32 bits at default CW)
//   kp_count    out  records accepted this frame (saturating)
//   drop_count  out  keypoints lost to a full FIFO (saturating)
//   overflow    out  sticky, set on the first drop until the next start
//   busy        out  high in COLLECT or DRAIN
//   done        out  high in DONE
// ---------------------------------------------------------------------------
module sift_kp_collect #(
    parameter int IMG_W   = 512,
    parameter int IMG_H   = 512,
    parameter int CW      = 9,
    parameter int FIFO_AW = 6
) (
    input  logic              clk_sys,
    input  logic              rst_sys,
    input  logic              start,
    input  logic              pix_en,
    input  logic              kp_in,
    input  logic [7:0]        mag,
    input  logic [5:0]        dir,
    input  logic              frame_done,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [2*CW+13:0]  m_data,
    output logic [15:0]       kp_count,
    output logic [15:0]       drop_count,
    output logic              overflow,
    output logic              busy,
    output logic              done
);

    localparam int REC_W = 2 * CW + 14;
    localparam int DEPTH = 1 << FIFO_AW;

    localparam logic [CW-1:0]    X_LAST  = CW'(IMG_W - 1);
    localparam logic [CW-1:0]    Y_LAST  = CW'(IMG_H - 1);
    localparam logic [CW-1:0]    CRD_ONE = CW'(1);
    localparam logic [FIFO_AW:0] PTR_ONE = (FIFO_AW + 1)'(1);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_DRAIN   = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [CW-1:0]      x_q, x_d;
    logic [CW-1:0]      y_q, y_d;
    logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
    logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
    logic [REC_W-1:0]   mem [0:DEPTH-1];
    logic               m_valid_q, m_valid_d;
    logic [REC_W-1:0]   m_data_q, m_data_d;
    logic [15:0]        kp_cnt_q, kp_cnt_d;
    logic [15:0]        drop_cnt_q, drop_cnt_d;
    logic               ovf_q, ovf_d;
    logic               busy_q, done_q;

    logic               in_collect;
    logic               pix_acc;
    logic               last_x;
    logic               last_y;
    logic               last_pix;
    logic               kp_cand;
    logic               fifo_full;
    logic               fifo_empty;
    logic               pop;
    logic               push;
    logic               drop;
    logic [REC_W-1:0]   rec;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    // ------------------------------------------------------------------
    // Input qualification
    // ------------------------------------------------------------------
    // start wins over pixel traffic in the same cycle: that cycle belongs
    // to the flush, not to the new frame.
    assign in_collect = (state_q == S_COLLECT);
    assign pix_acc    = in_collect & pix_en & ~start;
    assign last_x     = (x_q == X_LAST);
    assign last_y     = (y_q == Y_LAST);
    assign last_pix   = pix_acc & last_x & last_y;
    assign rec        = {y_q, x_q, mag, dir};

`ifdef SIFT_KP_NMS_EN
    // prev_kp_q stays set for the whole run of keypoint pixels, so a run
    // of adjacent keypoints produces only its first record. It never
    // carries across a row boundary.
    logic prev_kp_q, prev_kp_d;

    always_comb begin
        prev_kp_d = prev_kp_q;
        if (start) begin
            prev_kp_d = 1'b0;
        end else if (pix_acc) begin
            prev_kp_d = kp_in & ~last_x;
        end
    end

    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            prev_kp_q <= 1'b0;
        end else begin
            prev_kp_q <= prev_kp_d;
        end
    end

    assign kp_cand = pix_acc & kp_in & ~prev_kp_q;
`else
    assign kp_cand = pix_acc & kp_in;
`endif

    // ------------------------------------------------------------------
    // FIFO status
    // ------------------------------------------------------------------
    // The pointers carry one extra bit. Equal low bits with different MSBs
    // means full; identical pointers means empty.
    assign fifo_full  = (wr_ptr_q[FIFO_AW] != rd_ptr_q[FIFO_AW]) &&
                        (wr_ptr_q[FIFO_AW-1:0] == rd_ptr_q[FIFO_AW-1:0]);
    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign pop        = m_valid_q & m_ready;
    // A pop in the same cycle frees the head slot, so a push into a full
    // FIFO is still accepted.
    assign push       = kp_cand & (~fifo_full | pop);
    assign drop       = kp_cand & fifo_full & ~pop;

    // ------------------------------------------------------------------
    // FSM next state
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = S_COLLECT;
        end else begin
            case (state_q)
                S_IDLE:    state_d = S_IDLE;
                S_COLLECT: if (frame_done || last_pix) state_d = S_DRAIN;
                S_DRAIN:   if (fifo_empty) state_d = S_DONE;
                S_DONE:    state_d = S_DONE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Raster position
    // ------------------------------------------------------------------
    // The record uses the current position, then the position advances.
    // y stops at the last row because the frame ends at the last pixel.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (start) begin
            x_d = '0;
            y_d = '0;
        end else if (pix_acc) begin
            if (last_x) begin
                x_d = '0;
                if (!last_y) begin
                    y_d = y_q + CRD_ONE;
                end
            end else begin
                x_d = x_q + CRD_ONE;
            end
        end
    end

    // ------------------------------------------------------------------
    // Counters
    // ------------------------------------------------------------------
    always_comb begin
        kp_cnt_d   = kp_cnt_q;
        drop_cnt_d = drop_cnt_q;
        ovf_d      = ovf_q;
        if (start) begin
            kp_cnt_d   = '0;
            drop_cnt_d = '0;
            ovf_d      = 1'b0;
        end else begin
            if (push) begin
                kp_cnt_d = sat_inc16(kp_cnt_q);
            end
            if (drop) begin
                drop_cnt_d = sat_inc16(drop_cnt_q);
                ovf_d      = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // FIFO pointers and registered head
    // ------------------------------------------------------------------
    // The head register looks at the write pointer from before this edge's
    // push. A record written at edge N therefore reaches m_data at edge
    // N+1. The head slot is never written while it is presented, so
    // m_data stays stable during a stall.
    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        m_valid_d = m_valid_q;
        m_data_d  = m_data_q;
        if (start) begin
            wr_ptr_d  = '0;
            rd_ptr_d  = '0;
            m_valid_d = 1'b0;
        end else begin
            if (push) begin
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end
            m_valid_d = (wr_ptr_q != rd_ptr_d);
            // When the FIFO runs empty, m_data keeps the last record.
            if (m_valid_d) begin
                m_data_d = mem[rd_ptr_d[FIFO_AW-1:0]];
            end
        end
    end

    // ------------------------------------------------------------------
    // Storage
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys) begin
        if (push) begin
            mem[wr_ptr_q[FIFO_AW-1:0]] <= rec;
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_sys or negedge rst_sys) begin
        if (!rst_sys) begin
            state_q    <= S_IDLE;
            x_q        <= '0;
            y_q        <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            m_valid_q  <= 1'b0;
            m_data_q   <= '0;
            kp_cnt_q   <= '0;
            drop_cnt_q <= '0;
            ovf_q      <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            m_valid_q  <= m_valid_d;
            m_data_q   <= m_data_d;
            kp_cnt_q   <= kp_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            ovf_q      <= ovf_d;
            // Status flags are decoded from the next state so they line
            // up with state_q.
            busy_q     <= (state_d == S_COLLECT) || (state_d == S_DRAIN);
            done_q     <= (state_d == S_DONE);
        end
    end

    assign m_valid    = m_valid_q;
    assign m_data     = m_data_q;
    assign kp_count   = kp_cnt_q;
    assign drop_count = drop_cnt_q;
    assign overflow   = ovf_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_sift_kp_collect.sv
module tb_sift_kp_collect;

    localparam int IMG_W = 512;
    localparam int IMG_H = 4;
    localparam int CW    = 9;
    localparam int AW    = 6;
`ifdef SIFT_KP_NMS_EN
    localparam bit NMS = 1'b1;
`else
    localparam bit NMS = 1'b0;
`endif
    // With suppression on, keypoints that must all be pushed are spaced
    // one pixel apart.
    localparam int KSTRIDE = NMS ? 2 : 1;

    logic        clk_sys = 1'b0;
    logic        rst_sys;
    logic        start;
    logic        pix_en;
    logic        kp_in;
    logic [7:0]  mag;
    logic [5:0]  dir;
    logic        frame_done;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [15:0] kp_count;
    logic [15:0] drop_count;
    logic        overflow;
    logic        busy;
    logic        done;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] exp_q[$];
    int          mx = 0;
    int          my = 0;
    int          kps[10] = '{0, 5, 300, 511, 512, 1000, 1500, 2000, 2040, 2047};

    always #5 clk_sys = ~clk_sys;

    sift_kp_collect #(
        .IMG_W  (IMG_W),
        .IMG_H  (IMG_H),
        .CW     (CW),
        .FIFO_AW(AW)
    ) dut (
        .clk_sys   (clk_sys),
        .rst_sys   (rst_sys),
        .start     (start),
        .pix_en    (pix_en),
        .kp_in     (kp_in),
        .mag       (mag),
        .dir       (dir),
        .frame_done(frame_done),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .kp_count  (kp_count),
        .drop_count(drop_count),
        .overflow  (overflow),
        .busy      (busy),
        .done      (done)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        mx = 0;
        my = 0;
    endtask

    // Drive one pixel. When acc is set, the record built from the bench's
    // own raster position is queued as the expected output.
    task automatic send_pix(input bit kp, input logic [7:0] m, input logic [5:0] d, input bit acc);
        logic [8:0] xs;
        logic [8:0] ys;
        xs = mx[8:0];
        ys = my[8:0];
        pix_en = 1'b1;
        kp_in  = kp;
        mag    = m;
        dir    = d;
        if (kp && acc) exp_q.push_back({ys, xs, m, d});
        tick();
        pix_en = 1'b0;
        kp_in  = 1'b0;
        if (mx == IMG_W - 1) begin
            mx = 0;
            my++;
        end else begin
            mx++;
        end
    endtask

    task automatic wait_empty(input string nm, input int budget);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, exp_q.size(), 0);
    endtask

    task automatic wait_done(input string nm, input int budget);
        int n;
        n = 0;
        while (done !== 1'b1 && n < budget) begin
            tick();
            n++;
        end
        chk(nm, done, 1);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_m_valid"},  m_valid,    0);
        chk({tag, "_m_data"},   m_data,     0);
        chk({tag, "_kp_count"}, kp_count,   0);
        chk({tag, "_drop"},     drop_count, 0);
        chk({tag, "_overflow"}, overflow,   0);
        chk({tag, "_busy"},     busy,       0);
        chk({tag, "_done"},     done,       0);
    endtask

    // Monitor: each accepted transfer is compared with the scoreboard head.
    always @(negedge clk_sys) begin
        if (rst_sys === 1'b1 && m_valid === 1'b1 && m_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL rec_unexpected actual=%h expected=none", m_data);
            end else begin
                chk("rec", m_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] last_rec;
        bit          iskp;

        rst_sys = 1'b0; start = 1'b0; pix_en = 1'b0; kp_in = 1'b0;
        mag = '0; dir = '0; frame_done = 1'b0; m_ready = 1'b0;
        idle(3);
        check_reset_vals("rst");
        rst_sys = 1'b1;
        idle(2);

        // Pixels in IDLE are ignored.
        send_pix(1'b1, 8'h11, 6'h01, 1'b0);
        idle(2);
        chk("idle_ignore_valid", m_valid, 0);
        chk("idle_ignore_kp", kp_count, 0);

        // One keypoint at (1,1) after 513 plain pixels.
        do_start();
        chk("busy_collect", busy, 1);
        m_ready = 1'b1;
        for (int i = 0; i < 513; i++) send_pix(1'b0, 8'h00, 6'h00, 1'b0);
        send_pix(1'b1, 8'hA5, 6'h2A, 1'b1);
        chk("lat_edge0_valid", m_valid, 0);
        tick();
        chk("lat_edge1_valid", m_valid, 1);
        chk("lat_edge1_data", m_data, 32'h0080696A);
        chk("kp_one", kp_count, 1);
        wait_empty("drain_single", 20);

        // Fill past capacity with the consumer stalled.
        do_start();
        m_ready = 1'b0;
        for (int i = 0; i < 70; i++) begin
            send_pix(1'b1, 8'(i + 1), 6'(i + 1), i < 64);
            if (KSTRIDE == 2) send_pix(1'b0, 8'h00, 6'h00, 1'b0);
        end
        idle(2);
        chk("fill_drop", drop_count, 6);
        chk("fill_overflow", overflow, 1);
        chk("fill_kp", kp_count, 64);
        chk("stall_valid", m_valid, 1);
        chk("stall_head", m_data, 32'h00000041);

        // Full FIFO, pop and push in the same cycle.
        m_ready = 1'b1;
        send_pix(1'b1, 8'd200, 6'd5, 1'b1);
        m_ready = 1'b0;
        last_rec = {9'd0, 9'(70 * KSTRIDE), 8'd200, 6'd5};
        if (KSTRIDE == 2) send_pix(1'b0, 8'h00, 6'h00, 1'b0);
        // Occupancy is still 64, so this one is lost.
        send_pix(1'b1, 8'd201, 6'd6, 1'b0);
        idle(1);
        chk("full_pp_drop", drop_count, 7);
        chk("full_pp_kp", kp_count, 65);
        m_ready = 1'b1;
        wait_empty("drain_full", 200);
        idle(2);
        chk("empty_valid", m_valid, 0);
        chk("empty_hold_data", m_data, last_rec);

        // Whole frame, no frame_done: the last pixel ends collection.
        do_start();
        m_ready = 1'b1;
        for (int p = 0; p < IMG_W * IMG_H; p++) begin
            iskp = 1'b0;
            for (int k = 0; k < 10; k++) if (kps[k] == p) iskp = 1'b1;
            send_pix(iskp, 8'(p), 6'(p), 1'b1);
        end
        chk("frame_drain_busy", busy, 1);
        wait_done("frame_done_flag", 50);
        chk("frame_busy_low", busy, 0);
        chk("frame_kp", kp_count, 10);
        chk("frame_drop", drop_count, 0);
        chk("frame_valid", m_valid, 0);
        chk("frame_all_popped", exp_q.size(), 0);
        send_pix(1'b1, 8'h33, 6'h03, 1'b0);
        idle(2);
        chk("done_ignore_kp", kp_count, 10);
        chk("done_ignore_valid", m_valid, 0);

        // Reset mid-frame with records queued.
        do_start();
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            send_pix(1'b1, 8'(i + 50), 6'(i), 1'b0);
            if (KSTRIDE == 2) send_pix(1'b0, 8'h00, 6'h00, 1'b0);
        end
        idle(2);
        chk("pre_rst_valid", m_valid, 1);
        chk("pre_rst_kp", kp_count, 5);
        rst_sys = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 0);
        tick();
        check_reset_vals("midrst");
        rst_sys = 1'b1;
        idle(1);

        // Adjacent keypoints from (0,0); then frame_done ends the frame.
        do_start();
        m_ready = 1'b1;
        for (int j = 0; j < 4; j++) send_pix(1'b1, 8'(j + 10), 6'(j), !NMS || j == 0);
        send_pix(1'b0, 8'h00, 6'h00, 1'b0);
        idle(3);
        chk("adj_kp", kp_count, NMS ? 1 : 4);
        chk("adj_drop", drop_count, 0);
        frame_done = 1'b1;
        tick();
        frame_done = 1'b0;
        chk("fdone_busy", busy, 1);
        wait_done("fdone_done", 50);
        chk("fdone_all_popped", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
